stream_grant_mux: RTL

STREAM_GRANT_MUX -- requirements
Module: stream_grant_mux

---
 rtl/stream_mux_pkg.sv | 10 +
 rtl/stream_skid_buf.sv | 46 ++++
 rtl/stream_grant_mux.sv | 120 ++++++++++++
 3 files changed

// File: rtl/stream_mux_pkg.sv
// Shared definitions for the stream grant multiplexer.
package stream_mux_pkg;

    // Frame-level state of the mux: waiting for a grant, or streaming one frame.
    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } mux_state_t;

endpackage

// File: rtl/stream_skid_buf.sv
// Two-entry skid buffer: registered output stage plus one overflow slot.
// in_ready depends only on local state, so upstream never sees a
// combinational path from out_ready. Beats appear one cycle after push.
module stream_skid_buf #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [W-1:0] out_data,
    output logic         out_valid,
    input  logic         out_ready
);

    logic [W-1:0] skid_data;
    logic         skid_valid;

    // The buffer is full once the overflow slot holds a beat.
    assign in_ready = !skid_valid;

    // Output stage refills from the skid slot first, then from the input;
    // when the output is stalled, a new beat parks in the skid slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data   <= '0;
            out_valid  <= 1'b0;
            skid_data  <= '0;
            skid_valid <= 1'b0;
        end else if (!out_valid || out_ready) begin
            if (skid_valid) begin
                out_data   <= skid_data;
                out_valid  <= 1'b1;
                skid_valid <= 1'b0;
            end else begin
                out_valid <= in_valid;
                if (in_valid) out_data <= in_data;
            end
        end else if (in_valid) begin
            skid_data  <= in_data;
            skid_valid <= 1'b1;
        end
    end

endmodule

// File: rtl/stream_grant_mux.sv
// Frame-granular N:1 stream multiplexer driven by an external arbiter.
// The arbiter's grant is sampled only at frame start; the selected port
// then owns the output until its last beat is accepted.
// Optional grant-protocol checking: define STREAM_GRANT_MUX_CHECK_EN.
module stream_grant_mux
    import stream_mux_pkg::*;
#(
    parameter int PORTS      = 4,
    parameter int DATA_WIDTH = 64
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [PORTS*DATA_WIDTH-1:0]   s_data,
    input  logic [PORTS-1:0]              s_valid,
    input  logic [PORTS-1:0]              s_last,
    output logic [PORTS-1:0]              s_ready,
    output logic [PORTS-1:0]              request,
    output logic [PORTS-1:0]              acknowledge,
    input  logic [PORTS-1:0]              grant,
    input  logic                          grant_valid,
    input  logic [$clog2(PORTS)-1:0]      grant_encoded,
    output logic [DATA_WIDTH-1:0]         m_data,
    output logic                          m_valid,
    output logic                          m_last,
    output logic [$clog2(PORTS)-1:0]      m_src,
    input  logic                          m_ready,
    output logic                          err_grant
);

    localparam int SEL_W = $clog2(PORTS);
    localparam int PW    = DATA_WIDTH + 1 + SEL_W;

    mux_state_t             state;
    logic [SEL_W-1:0]       sel;
    logic [SEL_W-1:0]       cur_sel;
    logic                   start;
    logic                   engaged;
    logic                   buf_ready;
    logic                   accept;
    logic                   beat_last;
    logic [DATA_WIDTH-1:0]  beat_data;
    logic [DATA_WIDTH-1:0]  port_data [PORTS];
    logic [PW-1:0]          out_payload;

    // The one-hot grant carries the same information as grant_encoded.
    logic unused_grant;
    assign unused_grant = ^grant;

    assign request = s_valid;

    // A frame starts only when the granted port actually has a beat.
    assign start   = (state == IDLE) && grant_valid && s_valid[grant_encoded];
    assign cur_sel = (state == ACTIVE) ? sel : grant_encoded;
    // Gated by rst_n so s_ready drops the instant reset asserts.
    assign engaged = rst_n && ((state == ACTIVE) || start);

    genvar i;
    generate
        for (i = 0; i < PORTS; i++) begin : g_port
            assign port_data[i] = s_data[i*DATA_WIDTH +: DATA_WIDTH];
            assign s_ready[i]   = engaged && buf_ready && (cur_sel == SEL_W'(i));
        end
    endgenerate

    assign beat_data = port_data[cur_sel];
    assign beat_last = s_last[cur_sel];
    assign accept    = |(s_valid & s_ready);

    // Frame FSM: latch the granted port at start, release on its last beat;
    // a single-beat frame never leaves IDLE. acknowledge pulses one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            sel         <= '0;
            acknowledge <= '0;
        end else begin
            acknowledge <= '0;
            if (accept && beat_last) acknowledge[cur_sel] <= 1'b1;
            case (state)
                IDLE: begin
                    if (start) begin
                        sel   <= grant_encoded;
                        state <= (accept && beat_last) ? IDLE : ACTIVE;
                    end
                end
                ACTIVE: begin
                    if (accept && beat_last) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    stream_skid_buf #(.W(PW)) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   ({beat_last, cur_sel, beat_data}),
        .in_valid  (accept),
        .in_ready  (buf_ready),
        .out_data  (out_payload),
        .out_valid (m_valid),
        .out_ready (m_ready)
    );

    assign {m_last, m_src, m_data} = out_payload;

`ifdef STREAM_GRANT_MUX_CHECK_EN
    // Sticky flag: the arbiter must hold a valid grant on sel for the whole frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_grant <= 1'b0;
        end else if (state == ACTIVE && (!grant_valid || grant_encoded != sel)) begin
            err_grant <= 1'b1;
        end
    end
`else
    assign err_grant = 1'b0;
`endif

endmodule
